// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - FSM state encoding (IDLE, READ_MEM, UPDATE)
//   - field widths of the fetch address (offset 2, index 3, tag 3) and line (128)
//   - slicing constants that locate each field inside the byte address
//   - helpers that split a latched block address into index and tag
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ_MEM = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 3;
  localparam int LINE_W     = 128;
  localparam int BLK_ADDR_W = INDEX_W + TAG_W;

  // Bit positions inside the byte address: [1:0] byte, [3:2] word, [6:4] index, [9:7] tag
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

  // Line index held in the low bits of a block address
  function automatic logic [INDEX_W-1:0] blk_index(input logic [BLK_ADDR_W-1:0] blk);
    return blk[INDEX_W-1:0];
  endfunction

  // Tag held in the high bits of a block address
  function automatic logic [TAG_W-1:0] blk_tag(input logic [BLK_ADDR_W-1:0] blk);
    return blk[BLK_ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/icache_word_sel.sv
// -----------------------------------------------------------------------------
// icache_word_sel
// Combinational word selector: picks one 32-bit word out of a cache line
// using the word offset. Word 0 sits in the least significant bits.
// Ports:
//   line_i   in  WORDS*32  cache line
//   offset_i in  log2(WORDS) word offset within the line
//   word_o   out 32        selected word
// -----------------------------------------------------------------------------
module icache_word_sel
  import icache_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic [WORDS*WORD_W-1:0]  line_i,
  input  logic [$clog2(WORDS)-1:0] offset_i,
  output logic [WORD_W-1:0]        word_o
);

  // Offset-driven part select of the line
  always_comb begin
    word_o = line_i[int'(offset_i)*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
// Direct-mapped, read-only instruction cache: 8 lines x 4 words over a
// 1024-byte instruction space. Hits return combinationally; a miss stalls the
// CPU, fetches the whole 16-byte block and refills the line.
// Ports:
//   CLK           in   1    system clock, rising edge
//   RESET         in   1    asynchronous active-high reset
//   PC            in   32   fetch byte address (bits [1:0], [31:ADDR_W] ignored)
//   INSTRUCTION   out  32   fetched word, valid while BUSYWAIT is low
//   BUSYWAIT      out  1    CPU stall
//   MEM_READ      out  1    block read request
//   MEM_ADDRESS   out  6    block address of the miss being filled
//   MEM_READDATA  in   128  block from memory, word 0 in [31:0]
//   MEM_BUSYWAIT  in   1    memory busy
//   HIT_COUNT     out  16   saturating hit counter   (ICACHE_STATS_EN only)
//   MISS_COUNT    out  16   saturating miss counter  (ICACHE_STATS_EN only)
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module icache_direct
  import icache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int BLOCKS          = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [LINE_W-1:0]     MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  // Address fields of the current fetch
  logic [OFFSET_W-1:0]   offset_s;
  logic [INDEX_W-1:0]    index_s;
  logic [TAG_W-1:0]      tag_s;
  logic [BLK_ADDR_W-1:0] pc_blk_s;
  logic                  unused_pc_s;

  assign offset_s    = PC[INDEX_LSB-1:OFFSET_LSB];
  assign index_s     = PC[TAG_LSB-1:INDEX_LSB];
  assign tag_s       = PC[ADDR_W-1:TAG_LSB];
  assign pc_blk_s    = PC[ADDR_W-1:INDEX_LSB];
  assign unused_pc_s = ^{PC[31:ADDR_W], PC[OFFSET_LSB-1:0]};

  // Line storage: valid bits carry reset, tag/data arrays do not need it
  logic [BLOCKS-1:0]     valid_q;
  logic [TAG_W-1:0]      tag_q  [BLOCKS];
  logic [LINE_W-1:0]     data_q [BLOCKS];

  state_t                state_q, state_d;
  logic [BLK_ADDR_W-1:0] addr_q, addr_d;

  logic                  hit_s;
  logic                  fill_s;
  logic                  busy_s;
  logic                  mem_read_s;
  logic [BLK_ADDR_W-1:0] mem_addr_s;
  logic [WORD_W-1:0]     word_s;

  assign hit_s = valid_q[index_s] && (tag_q[index_s] == tag_s);

  icache_word_sel #(
    .WORDS (WORDS_PER_BLOCK)
  ) u_word_sel (
    .line_i   (data_q[index_s]),
    .offset_i (offset_s),
    .word_o   (word_s)
  );

  // Next-state and output decode of the miss-handling FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    busy_s     = 1'b0;
    mem_read_s = 1'b0;
    mem_addr_s = '0;
    fill_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit_s) begin
          // Latch the missing block so later PC changes cannot redirect the fill
          state_d = ST_READ_MEM;
          addr_d  = pc_blk_s;
          busy_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ_MEM: begin
        busy_s     = 1'b1;
        mem_read_s = 1'b1;
        mem_addr_s = addr_q;
        if (!MEM_BUSYWAIT) begin
          fill_s  = 1'b1;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_READ_MEM;
        end
      end
      ST_UPDATE: begin
        busy_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched block address and valid bits
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (fill_s) begin
        valid_q[blk_index(addr_q)] <= 1'b1;
      end
    end
  end

  // Line refill: tag and data written on the memory's completion edge
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_q[blk_index(addr_q)]  <= blk_tag(addr_q);
      data_q[blk_index(addr_q)] <= MEM_READDATA;
    end
  end

  // CPU-side outputs are held quiet while reset is asserted
  assign BUSYWAIT    = busy_s & ~RESET;
  assign INSTRUCTION = RESET ? '0 : word_s;
  assign MEM_READ    = mem_read_s;
  assign MEM_ADDRESS = mem_addr_s;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating per-fetch hit and miss counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      if ((state_q == ST_IDLE) && hit_s && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if ((state_q == ST_IDLE) && !hit_s && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
// Scoreboard bench for icache_direct. The driver pushes the expected word and
// stall length of each fetch (and the expected block address of each fill);
// a monitor pops and compares whenever the cache releases BUSYWAIT or starts
// a memory read. Memory word at byte address a is {16'hC0DE, 6'b0, a[9:0]}.
// -----------------------------------------------------------------------------
module tb_icache_direct;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  icache_direct dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- memory model ----------------
  int mem_lat;
  int mem_cnt;

  always @(posedge CLK) begin
    if (MEM_READ) mem_cnt <= mem_cnt + 1;
    else          mem_cnt <= 0;
  end

  // Busy from the first READ cycle until the mem_lat-th one
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt != mem_lat - 1);

  always_comb begin
    MEM_READDATA = '0;
    for (int w = 0; w < 4; w++) begin
      MEM_READDATA[w*32 +: 32] = {16'hC0DE, 6'd0, MEM_ADDRESS, 2'(w), 2'b00};
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          busy;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] addr_exp_q[$];
  int         n_cmp;
  int         n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compares each released fetch and each new memory read
  initial begin
    int   busy_cnt;
    logic prev_read;
    exp_t e;
    logic [5:0] a;
    busy_cnt  = 0;
    prev_read = 1'b0;
    forever begin
      @(negedge CLK);
      if (MEM_READ && !prev_read) begin
        if (addr_exp_q.size() == 0) begin
          check("unexpected_mem_read", 32'(MEM_ADDRESS), 32'hFFFF_FFFF);
        end else begin
          a = addr_exp_q.pop_front();
          check("mem_address", 32'(MEM_ADDRESS), 32'(a));
        end
      end
      prev_read = MEM_READ;
      if (RESET || exp_q.size() == 0) begin
        busy_cnt = 0;
      end else if (BUSYWAIT) begin
        busy_cnt++;
      end else begin
        e = exp_q.pop_front();
        check($sformatf("instr pc=%h", e.pc), INSTRUCTION, e.instr);
        check($sformatf("stall pc=%h", e.pc), 32'(busy_cnt), 32'(e.busy));
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] instr,
                              input int busy, input bit miss, input logic [5:0] blk);
    exp_t e;
    e.pc = pc; e.instr = instr; e.busy = busy;
    exp_q.push_back(e);
    if (miss) addr_exp_q.push_back(blk);
    PC = pc;
  endtask

  task automatic wait_accept(input logic [31:0] pc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fetch_timeout pc=%h: BUSYWAIT still 1, required 0", pc);
    end
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                       input int busy, input bit miss, input logic [5:0] blk);
    expect_fetch(pc, instr, busy, miss, blk);
    wait_accept(pc);
  endtask

  task automatic wait_mem_read();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLK); #1;
      if (MEM_READ) seen = 1'b1;
    end
    check("mem_read_start", 32'(seen), 32'd1);
  endtask

  task automatic reset_pulse();
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    mem_lat = 5;
    RESET   = 1'b1;
    PC      = 32'd0;

    // Reset state: outputs quiet while RESET is high
    #3;
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    check("rst_instruction", INSTRUCTION, 32'd0);
    @(posedge CLK); #1;
    check("rst_busywait_edge", 32'(BUSYWAIT), 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", 32'(HIT_COUNT), 32'd0);
    check("rst_miss_count", 32'(MISS_COUNT), 32'd0);
`endif
    RESET = 1'b0;

    // Cold miss at PC=0, latency 5 -> 7 stall cycles
    fetch(32'd0, 32'hC0DE_0000, 7, 1'b1, 6'd0);

    // Sequential hits within block 0
    fetch(32'd4,  32'hC0DE_0004, 0, 1'b0, 6'd0);
    fetch(32'd8,  32'hC0DE_0008, 0, 1'b0, 6'd0);
    fetch(32'd12, 32'hC0DE_000C, 0, 1'b0, 6'd0);
`ifdef ICACHE_STATS_EN
    check("hit_count", 32'(HIT_COUNT), 32'd4);
    check("miss_count", 32'(MISS_COUNT), 32'd1);
`endif

    // Conflict on index 1: blocks 1, 9, 1
    fetch(32'd16,  32'hC0DE_0010, 7, 1'b1, 6'd1);
    fetch(32'd144, 32'hC0DE_0090, 7, 1'b1, 6'd9);
    fetch(32'd16,  32'hC0DE_0010, 7, 1'b1, 6'd1);

    // Reset on cycle 3 of READ_MEM: fill abandoned, line 0 stays invalid
    PC = 32'd0;
    addr_exp_q.push_back(6'd0);
    reset_pulse();
    wait_mem_read();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2;
    RESET = 1'b1;
    #1;
    check("midfill_rst_mem_read", 32'(MEM_READ), 32'd0);
    check("midfill_rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("midfill_rst_instr", INSTRUCTION, 32'd0);
`ifdef ICACHE_STATS_EN
    check("midfill_rst_hit_count", 32'(HIT_COUNT), 32'd0);
`endif
    @(posedge CLK); #1;
    RESET = 1'b0;
    fetch(32'd0, 32'hC0DE_0000, 7, 1'b1, 6'd0);

    // PC moves to 32 during the fill of block 0: block 0 still filled, then block 2
    PC = 32'd0;
    addr_exp_q.push_back(6'd0);
    reset_pulse();
    wait_mem_read();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    expect_fetch(32'd32, 32'hC0DE_0020, 11, 1'b1, 6'd2);
    wait_accept(32'd32);
    fetch(32'd0,  32'hC0DE_0000, 0, 1'b0, 6'd0);
    fetch(32'd36, 32'hC0DE_0024, 0, 1'b0, 6'd0);

    // Zero-latency memory: 3-cycle penalty, top of address space, high PC bits ignored
    mem_lat = 1;
    fetch(32'd424,        32'hC0DE_01A8, 3, 1'b1, 6'd26);
    fetch(32'd1020,       32'hC0DE_03FC, 3, 1'b1, 6'd63);
    fetch(32'h8000_03F0,  32'hC0DE_03F0, 0, 1'b0, 6'd0);

    repeat (3) @(posedge CLK);
    #1;
    check("pending_fetches", 32'(exp_q.size()), 32'd0);
    check("pending_fills", 32'(addr_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
